// File: rtl/band_energy_window.sv
`default_nettype none
// ============================================================================
//  Module      : band_energy_window
//  Description : Mean-square (band power) feature extractor. Squares each
//                signed 8-bit filtered sample, sums WINDOW squares and emits
//                (sum >> log2(WINDOW)), saturated to OUT_W, through a
//                one-entry output slot with a valid/ready handshake.
//
//  Ports
//    clk        in   1        rising-edge clock
//    reset_n    in   1        asynchronous active-low reset
//    i_data     in   8        signed filtered sample
//    i_valid    in   1        sample strobe (no backpressure)
//    i_clear    in   1        synchronous abort of the current window
//    o_data     out  OUT_W    unsigned mean-square of last completed window
//    o_valid    out  1        o_data holds an unconsumed result
//    i_ready    in   1        consumer takes o_data when o_valid & i_ready
//    o_overrun  out  1        one-cycle pulse: unconsumed result overwritten
//    o_fill     out  clog2(WINDOW)  squares accumulated in current window
//
//  Revision    : 1.0  initial release
// ============================================================================
module band_energy_window #(
    parameter int WINDOW = 64,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 i_data,
    input  logic                       i_valid,
    input  logic                       i_clear,
    output logic [OUT_W-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_overrun,
    output logic [$clog2(WINDOW)-1:0]  o_fill
);

    localparam int                    c_LOG2   = $clog2(WINDOW);
    localparam int                    c_FILL_W = $clog2(WINDOW);
    localparam logic [c_FILL_W-1:0]   c_LAST   = c_FILL_W'(WINDOW - 1);

    generate
        if (ACC_W < 15 + $clog2(WINDOW)) begin : g_acc_w_check
            $error("band_energy_window: ACC_W too small for WINDOW");
        end
        if ((WINDOW < 2) || ((WINDOW & (WINDOW - 1)) != 0)) begin : g_window_check
            $error("band_energy_window: WINDOW must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Stage 1: square
    // ------------------------------------------------------------------------
    logic signed [15:0]  w_prod;
    logic [15:0]         r_sq;
    logic                r_sq_v;

    // Signed 8x8 product evaluated at 16 bits is exact; it is never negative,
    // so it is reinterpreted as unsigned (max 16384 at -128).
    assign w_prod = $signed(i_data) * $signed(i_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sq   <= '0;
            r_sq_v <= 1'b0;
        end else if (i_clear) begin
            r_sq_v <= 1'b0;
        end else begin
            r_sq_v <= i_valid;
            if (i_valid) begin
                r_sq <= unsigned'(w_prod);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: accumulate
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_total;
    logic [ACC_W-1:0]    w_shifted;
    logic [c_FILL_W-1:0] r_fill;
    logic                w_last;
    logic                w_done;
    logic [OUT_W-1:0]    w_result;

    assign w_total   = r_acc + ACC_W'(r_sq);
    assign w_shifted = w_total >> c_LOG2;
    assign w_last    = (r_fill == c_LAST);
    // A clear in the completing cycle cancels the completion.
    assign w_done    = r_sq_v & w_last & ~i_clear;

    generate
        if (ACC_W > OUT_W) begin : g_sat
            assign w_result = (|w_shifted[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                          : w_shifted[OUT_W-1:0];
        end else begin : g_nosat
            assign w_result = OUT_W'(w_shifted);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (r_sq_v) begin
            if (w_last) begin
                // Window closes here; the next square starts a fresh window.
                r_acc  <= '0;
                r_fill <= '0;
            end else begin
                r_acc  <= w_total;
                r_fill <= r_fill + c_FILL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output slot FSM
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [OUT_W-1:0]    r_data;
    logic [OUT_W-1:0]    w_data_next;
    logic                r_overrun;
    logic                w_overrun_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_EMPTY;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_data    <= w_data_next;
            r_overrun <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_data_next    = r_data;
        w_overrun_next = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_done) begin
                    w_state_next = S_FULL;
                    w_data_next  = w_result;
                end
            end
            S_FULL: begin
                if (w_done) begin
                    // Either the old value is consumed this cycle or it is
                    // lost; both leave the slot full with the new result.
                    w_data_next    = w_result;
                    w_overrun_next = ~i_ready;
                end else if (i_ready) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    assign o_data    = r_data;
    assign o_valid   = (r_state == S_FULL);
    assign o_overrun = r_overrun;
    assign o_fill    = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_band_energy_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_band_energy_window
//  Description : Self-checking bench for band_energy_window. A sample-level
//                reference model (list of window samples, sum of squares,
//                integer mean) predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_band_energy_window;

    localparam int WINDOW = 64;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 16;
    localparam int FILL_W = $clog2(WINDOW);

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [7:0]         i_data = '0;
    logic               i_valid = 1'b0;
    logic               i_clear = 1'b0;
    logic               i_ready = 1'b0;
    logic [OUT_W-1:0]   o_data;
    logic               o_valid;
    logic               o_overrun;
    logic [FILL_W-1:0]  o_fill;

    band_energy_window #(
        .WINDOW (WINDOW),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_clear   (i_clear),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_overrun (o_overrun),
        .o_fill    (o_fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int win[$];          // samples already counted into the current window
    bit pend_v;          // a sample accepted but not yet counted
    int pend_d;
    bit m_full;
    int m_data;
    bit m_ovr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int window_power(input int s[$]);
        longint t;
        t = 0;
        foreach (s[i]) t += longint'(s[i]) * longint'(s[i]);
        t = t / WINDOW;
        if (t > (longint'(1) << OUT_W) - 1) t = (longint'(1) << OUT_W) - 1;
        return int'(t);
    endfunction

    function automatic void model_reset();
        win.delete();
        pend_v = 1'b0;
        pend_d = 0;
        m_full = 1'b0;
        m_data = 0;
        m_ovr  = 1'b0;
    endfunction

    // One clock cycle: drive, advance the model across the edge, check.
    task automatic step(input bit v, input int d, input bit c, input bit r);
        bit done;
        int res;
        done = 1'b0;
        res  = 0;
        i_valid = v;
        i_data  = 8'(d);
        i_clear = c;
        i_ready = r;
        @(posedge clk);
        if (c) begin
            win.delete();
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                win.push_back(pend_d);
                if (win.size() == WINDOW) begin
                    done = 1'b1;
                    res  = window_power(win);
                    win.delete();
                end
            end
            pend_v = v;
            pend_d = d;
        end
        m_ovr = done && m_full && !r;
        if (done) begin
            m_full = 1'b1;
            m_data = res;
        end else if (r) begin
            m_full = 1'b0;
        end
        #1;
        chk("o_valid", 32'(o_valid), 32'(m_full));
        if (m_full) chk("o_data", 32'(o_data), 32'(m_data));
        chk("o_overrun", 32'(o_overrun), 32'(m_ovr));
        chk("o_fill", 32'(o_fill), 32'(win.size()));
    endtask

    task automatic window(input int v, input bit r);
        for (int i = 0; i < WINDOW; i++) step(1'b1, v, 1'b0, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0;
        i_clear = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_fill", 32'(o_fill), 32'd0);
        chk("rst_o_overrun", 32'(o_overrun), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int d6[$];
        int r7;
        int r1;
        model_reset();
        do_reset();

        // T1: constant 16, latency and single-cycle hold
        window(16, 1'b1);
        chk("t1_not_yet", 32'(o_valid), 32'd0);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t1_valid", 32'(o_valid), 32'd1);
        chk("t1_data", 32'(o_data), 32'd256);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t1_consumed", 32'(o_valid), 32'd0);

        // T2: full-scale negative, then alternating +/-10 back-to-back
        window(-128, 1'b1);
        for (int i = 0; i < WINDOW; i++) step(1'b1, (i % 2) ? -10 : 10, 1'b0, 1'b1);
        chk("t2_max", 32'(o_data), 32'd16384);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t2_alt", 32'(o_data), 32'd100);
        step(1'b0, 0, 1'b0, 1'b1);

        // T3: overwrite with and without consumer ready
        window(16, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t3_first", 32'(o_data), 32'd256);
        window(8, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t3_ovr_pulse", 32'(o_overrun), 32'd1);
        chk("t3_ovr_data", 32'(o_data), 32'd64);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t3_ovr_1cyc", 32'(o_overrun), 32'd0);
        step(1'b0, 0, 1'b0, 1'b1);
        window(16, 1'b0);
        window(8, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t3_no_ovr", 32'(o_overrun), 32'd0);
        chk("t3_ready_data", 32'(o_data), 32'd64);
        step(1'b0, 0, 1'b0, 1'b1);

        // T4: clear with concurrent sample
        for (int i = 0; i < 30; i++) step(1'b1, 100, 1'b0, 1'b1);
        step(1'b1, 50, 1'b1, 1'b1);
        chk("t4_fill_clr", 32'(o_fill), 32'd0);
        window(4, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t4_data", 32'(o_data), 32'd16);
        step(1'b0, 0, 1'b0, 1'b1);

        // T5: asynchronous reset mid-window with a held result
        window(16, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 7, 1'b0, 1'b0);
        do_reset();
        window(2, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t5_data", 32'(o_data), 32'd4);
        step(1'b0, 0, 1'b0, 1'b1);

        // T6: filter cadence vs back-to-back, identical data
        for (int i = 0; i < WINDOW; i++) d6.push_back(int'($urandom_range(255)) - 128);
        for (int i = 0; i < WINDOW; i++) begin
            step(1'b1, d6[i], 1'b0, 1'b1);
            for (int k = 0; k < 6; k++) step(1'b0, 0, 1'b0, 1'b1);
        end
        r7 = int'(o_data);
        chk("t6_cad7", 32'(r7), 32'(window_power(d6)));
        for (int i = 0; i < WINDOW; i++) step(1'b1, d6[i], 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        r1 = int'(o_data);
        chk("t6_same", 32'(r1), 32'(r7));
        step(1'b0, 0, 1'b0, 1'b1);

        // Random traffic: sparse strobes, rare clears, random consumer
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(9) < 6), int'($urandom_range(255)) - 128,
                 ($urandom_range(79) == 0), $urandom_range(1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
